// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the single-ported RAM.
// The arbiter takes the slave view; the requesters and RAM together form the master view.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              iwait;
    logic [DATA_W-1:0] iload;

    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              dwait;
    logic [DATA_W-1:0] dload;

    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Grants the single RAM port to either the data path (preferred) or instruction fetch,
// with a completion-streak limit so fetch cannot be starved by back-to-back data accesses.
module ram_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic                 CLK,
    input  logic                 nRST,
    ram_port_arbiter_if.slave    bus
);
    localparam int SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] DMAX = SW'(MAX_DSTREAK);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   dstreak, dstreak_nxt;
    logic            ram_err_q;
    logic            dreq;
    logic            access;

    function automatic state_t arbitrate(input logic d, input logic i, input logic [SW-1:0] streak);
        if (d && !(i && streak == DMAX)) begin
            return DGNT;
        end else if (i) begin
            return IGNT;
        end
        return IDLE;
    endfunction

    assign dreq   = bus.dREN | bus.dWEN;
    assign access = (bus.ramstate == RS_ACCESS);

    assign bus.iload   = bus.ramload;
    assign bus.dload   = bus.ramload;
    assign bus.ram_err = ram_err_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            dstreak   <= '0;
            ram_err_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            dstreak <= dstreak_nxt;
            if (state != IDLE && bus.ramstate == RS_ERROR) begin
                ram_err_q <= 1'b1;
            end
        end
    end

    // RAM controls decode from the current grant and the live request, so a dropped
    // request or a mid-grant address change reaches the RAM in the same cycle.
    always_comb begin
        state_nxt    = state;
        dstreak_nxt  = dstreak;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = {ADDR_W{1'b0}};
        bus.ramstore = {DATA_W{1'b0}};
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;

        case (state)
            IDLE: begin
                state_nxt = arbitrate(dreq, bus.iREN, dstreak);
            end
            DGNT: begin
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                if (bus.dWEN) begin
                    bus.ramWEN = 1'b1;
                end else if (bus.dREN) begin
                    bus.ramREN = 1'b1;
                end
                if (!dreq) begin
                    state_nxt = IDLE;
                end else if (access) begin
                    bus.dwait = 1'b0;
                    if (bus.iREN) begin
                        dstreak_nxt = (dstreak == DMAX) ? DMAX : dstreak + 1'b1;
                    end else begin
                        dstreak_nxt = '0;
                    end
                    // Arbitrate on the updated streak so the limit counts this completion.
                    state_nxt = arbitrate(dreq, bus.iREN, dstreak_nxt);
                end
            end
            IGNT: begin
                bus.ramaddr = bus.iaddr;
                if (!bus.iREN) begin
                    state_nxt = IDLE;
                end else begin
                    bus.ramREN = 1'b1;
                    if (access) begin
                        bus.iwait   = 1'b0;
                        dstreak_nxt = '0;
                        state_nxt   = arbitrate(dreq, bus.iREN, '0);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule
